// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned CntWidth = 5;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_unit_negate32.sv
// Conditional two's-complement negation, used for operand magnitudes and result signs.
// The increment input lets two instances chain into a 64-bit negation.
module negate32 (
    input  logic [31:0] a,
    input  logic        neg,
    input  logic        inc,
    output logic [31:0] y
);

    // neg: y = ~a + inc; otherwise pass through
    assign y = neg ? (~a + {31'b0, inc}) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One shift-add or restoring-subtract step per RUN cycle on operand magnitudes;
// signs are restored on the committing edge.
module muldiv_unit #(
    parameter int unsigned WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             cancel,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import muldiv_pkg::*;

    state_e              state_q;
    logic [CntWidth-1:0] cnt_q;
    logic                pend_q;      // start registered, RUN begins next edge
    logic                is_div_q;
    logic                neg_prod_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic                div_zero_q;
    logic [WIDTH-1:0]    a_raw_q;     // original dividend, returned as HI on divide by zero
    logic [WIDTH-1:0]    b_q;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0]    acc_q;       // upper product half / partial remainder
    logic [WIDTH-1:0]    quo_q;       // multiplier bits / dividend bits then quotient
    logic [WIDTH-1:0]    hi_q;
    logic [WIDTH-1:0]    lo_q;
    logic                busy_q;
    logic                done_q;

    logic             op_div;
    logic             op_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] it_acc;
    logic [WIDTH-1:0] it_quo;
    logic [WIDTH-1:0] fix_lo;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;

    assign op_div    = (op == OpDiv) || (op == OpDivu);
    assign op_signed = (op == OpMult) || (op == OpDiv);

    negate32 u_mag_a (
        .a   (srcA),
        .neg (op_signed & srcA[WIDTH-1]),
        .inc (1'b1),
        .y   (mag_a)
    );

    negate32 u_mag_b (
        .a   (srcB),
        .neg (op_signed & srcB[WIDTH-1]),
        .inc (1'b1),
        .y   (mag_b)
    );

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        shifted = {acc_q, quo_q[WIDTH-1]};
        fits    = shifted >= {1'b0, b_q};
        sum     = {1'b0, acc_q} + (quo_q[0] ? {1'b0, b_q} : '0);
        if (is_div_q) begin
            it_acc = fits ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
            it_quo = {quo_q[WIDTH-2:0], fits};
        end else begin
            it_acc = sum[WIDTH:1];
            it_quo = {sum[0], quo_q[WIDTH-1:1]};
        end
    end

    // Product negation carries into the high half only when the low half is zero
    negate32 u_fix_lo (
        .a   (it_quo),
        .neg (is_div_q ? neg_quo_q : neg_prod_q),
        .inc (1'b1),
        .y   (fix_lo)
    );

    negate32 u_fix_hi (
        .a   (it_acc),
        .neg (is_div_q ? neg_rem_q : neg_prod_q),
        .inc (is_div_q | (it_quo == '0)),
        .y   (fix_hi)
    );

    assign res_lo = div_zero_q ? '1 : fix_lo;
    assign res_hi = div_zero_q ? a_raw_q : fix_hi;

    // Control FSM, datapath registers and HI/LO with registered busy/done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            is_div_q   <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            quo_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    if (we_hi) hi_q <= writeData;
                    if (we_lo) lo_q <= writeData;
                    if (pend_q && !cancel) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        cnt_q   <= CntWidth'(WIDTH - 1);
                        pend_q  <= 1'b0;
                    end else if (cancel) begin
                        pend_q <= 1'b0;
                    end else if (start) begin
                        pend_q     <= 1'b1;
                        is_div_q   <= op_div;
                        neg_prod_q <= !op_div && op_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        neg_quo_q  <= op_div && op_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        neg_rem_q  <= op_div && op_signed && srcA[WIDTH-1];
                        div_zero_q <= op_div && (srcB == '0);
                        a_raw_q    <= srcA;
                        b_q        <= op_div ? mag_b : mag_a;
                        quo_q      <= op_div ? mag_a : mag_b;
                        acc_q      <= '0;
                    end
                end
                StRun: begin
                    if (cancel) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= it_acc;
                        quo_q <= it_quo;
                        if (cnt_q == '0) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            hi_q    <= res_hi;
                            lo_q    <= res_lo;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized traffic
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        cancel;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] writeData;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .srcA      (srcA),
        .srcB      (srcB),
        .cancel    (cancel),
        .we_hi     (we_hi),
        .we_lo     (we_lo),
        .writeData (writeData),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Architectural result {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        int          sa;
        int          sb;
        longint      p;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Reference model: phase = edges since accepted start (-1 when nothing in flight)
    int          phase = -1;
    logic [1:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_busy;
    logic        m_done;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin : model
        int          prev;
        logic        running;
        logic [63:0] r;
        if (rst) begin
            phase   = -1;
            m_hi    = '0;
            m_lo    = '0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_valid = 1'b1;
        end else begin
            prev    = phase;
            running = (prev >= 1);
            m_done  = 1'b0;
            if (prev >= 0 && cancel) begin
                phase = -1;
            end else if (prev >= 0) begin
                phase = prev + 1;
                if (phase == 33) begin
                    r      = ref_result(m_op, m_a, m_b);
                    m_hi   = r[63:32];
                    m_lo   = r[31:0];
                    m_done = 1'b1;
                    phase  = -1;
                end
            end
            if (!running) begin
                if (we_hi) m_hi = writeData;
                if (we_lo) m_lo = writeData;
            end
            if (prev == -1 && start && !cancel) begin
                phase = 0;
                m_op  = op;
                m_a   = srcA;
                m_b   = srcB;
            end
            m_busy = (phase >= 1);
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if ({busy, done, hi, lo} !== {m_busy, m_done, m_hi, m_lo}) begin
                n_fail++;
                $display("FAIL cycle_model @%0t: busy/done/hi/lo got %b/%b/%h/%h want %b/%b/%h/%h",
                         $time, busy, done, hi, lo, m_busy, m_done, m_hi, m_lo);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one op, optionally inject an extra start at edge k+inj, wait for done
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj, output int lat);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        tick();
        start = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 60; n++) begin
            start = (n == inj);
            op    = 2'($urandom_range(0, 3));
            srcA  = $urandom;
            srcB  = $urandom;
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        srcA      = '0;
        srcB      = '0;
        cancel    = 1'b0;
        we_hi     = 1'b0;
        we_lo     = 1'b0;
        writeData = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);

        // Pin the model with hand-computed values
        chk("model_mult", ref_result(2'b00, 32'hFFFF_FFFF, 32'd2), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("model_div", ref_result(2'b10, -32'd7, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_divz", ref_result(2'b10, 32'h1234, 32'd0), 64'h0000_1234_FFFF_FFFF);

        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 0, lat);
        chk("mult_latency", lat, 33);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat);
        chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        run_op(2'b10, -32'd7, 32'd2, 0, lat);
        chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(2'b11, 32'd7, 32'd2, 0, lat);
        chk("divu_hilo", {hi, lo}, 64'h0000_0001_0000_0003);

        run_op(2'b11, 32'd100, 32'd7, 5, lat);
        chk("start_in_run_latency", lat, 33);
        chk("start_in_run_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        run_op(2'b10, 32'h1234, 32'd0, 0, lat);
        chk("divzero_latency", lat, 33);
        chk("divzero_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat);
        chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        // Preload HI/LO, then cancel an operation at RUN cycle 10
        tick();
        we_hi     = 1'b1;
        writeData = 32'hA;
        tick();
        we_hi     = 1'b0;
        we_lo     = 1'b1;
        writeData = 32'hB;
        tick();
        we_lo = 1'b0;
        chk("preload_hilo", {hi, lo}, 64'h0000_000A_0000_000B);
        start = 1'b1;
        op    = 2'b01;
        srcA  = 32'd3;
        srcB  = 32'd5;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            start = (n == 4);
            tick();
        end
        start  = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done) seen++;
        end
        chk("cancel_no_done", seen, 0);
        chk("cancel_hilo", {hi, lo}, 64'h0000_000A_0000_000B);

        // Reset at RUN cycle 5
        start = 1'b1;
        op    = 2'b01;
        srcA  = 32'h1_2345;
        srcB  = 32'h777;
        tick();
        start = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done) seen++;
        end
        chk("rst_no_done", seen, 0);

        // Randomized traffic, checked each cycle by the model
        seen = 0;
        for (int c = 0; c < 8000; c++) begin
            start     = ($urandom_range(0, 99) < 15);
            op        = 2'($urandom_range(0, 3));
            srcA      = pick();
            srcB      = pick();
            cancel    = ($urandom_range(0, 199) == 0);
            we_hi     = ($urandom_range(0, 29) == 0);
            we_lo     = ($urandom_range(0, 29) == 0);
            writeData = $urandom;
            rst       = ($urandom_range(0, 2999) == 0);
            tick();
            if (done) seen++;
        end
        start  = 1'b0;
        cancel = 1'b0;
        we_hi  = 1'b0;
        we_lo  = 1'b0;
        rst    = 1'b0;
        for (int n = 0; n < 40; n++) tick();
        chk("random_done_seen", (seen > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand, HI and LO width; only 32 is required to be supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation using op, srcA and srcB.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports srcA and srcB, input, WIDTH bits each: operands taken from register-file readData1 and readData2.
REQ-007 SHALL have port cancel, input, 1 bit: abort an in-flight operation (pipeline flush).
REQ-008 SHALL have ports we_hi and we_lo, input, 1 bit each, plus port writeData, input, WIDTH bits: MTHI/MTLO writes.
REQ-009 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking a completed operation.
REQ-011 SHALL have ports hi and lo, output, WIDTH bits each: the architectural HI/LO registers, read by MFHI/MFLO.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; a start is then registered and the state goes to RUN with the 5-bit iteration counter at 31.
REQ-014 SHALL ignore start while in RUN, with no queuing.
REQ-015 SHALL latch srcA, srcB and op on the accepting edge; later operand changes do not affect the result.
REQ-016 SHALL perform one shift-add (multiply) or restoring-subtract (divide) iteration per RUN cycle, on operand magnitudes, for exactly 32 cycles.
REQ-017 SHALL go RUN -> DONE on the edge at which the counter reaches 0, committing hi/lo on that same edge.
REQ-018 SHALL hold DONE for exactly one cycle, then return to IDLE (or to RUN if start is present).
REQ-019 SHALL have latency as follows: start sampled at edge k, so busy = 1 after edges k+1 through k+32, and done = 1 and hi/lo valid after edge k+33.
REQ-020 SHALL drive busy = 1 only in RUN and done = 1 only in DONE.
REQ-021 SHALL produce a MULT/MULTU result of 64 bits, with {hi, lo} = product; MULT is two's-complement signed.
REQ-022 SHALL, for DIV/DIVU, set lo = quotient and hi = remainder; for DIV the quotient sign is sA^sB, the remainder takes the dividend's sign, and the quotient truncates toward zero.
REQ-023 SHALL, for divide by zero (srcB = 0), set lo = 0xFFFFFFFF and hi = srcA, with normal latency and done still pulsed.
REQ-024 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, set lo = 0x80000000 and hi = 0, with no trap.
REQ-025 SHALL, on cancel in RUN, return to IDLE on the next edge with no done pulse and hi/lo unchanged.
REQ-026 SHALL treat cancel in IDLE or DONE as a no-op.
REQ-027 SHALL, when cancel and start occur together, give cancel priority: the start is dropped.
REQ-028 SHALL apply we_hi/we_lo writes of writeData to hi/lo on the next edge in IDLE or DONE, and ignore them in RUN.
REQ-029 SHALL, when a write occurs in the same cycle as an accepting start, perform the write and start the operation; the later commit overwrites hi/lo.

Reset
REQ-030 SHALL, on rst high at a rising clk edge, set state to IDLE, counter to 0, hi = 0, lo = 0, busy = 0 and done = 0.
REQ-031 SHALL give rst priority over start, cancel and writes.
REQ-032 SHALL, on rst mid-RUN, abandon the operation with no done pulse.

Structure
REQ-033 SHALL place the op encodings (MULT/MULTU/DIV/DIVU), the FSM state encodings and WIDTH in the shared package muldiv_pkg.
REQ-034 SHALL use one combinational sub-module, negate32, for two's-complement magnitude and sign restoration; all other logic stays in muldiv_unit.

Verification
REQ-035 SHALL verify: MULT srcA = 0xFFFFFFFF, srcB = 2 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFE, with done exactly 33 edges after start.
REQ-036 SHALL verify: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-037 SHALL verify: DIV -7/2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; and DIVU 7/2 -> lo = 3, hi = 1.
REQ-038 SHALL verify: DIV 0x1234/0 -> lo = 0xFFFFFFFF, hi = 0x1234; and DIV 0x80000000/0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-039 SHALL verify: after preloading hi = 0xA, lo = 0xB via we_hi/we_lo, a start followed by cancel at RUN cycle 10 gives no done and hi/lo = 0xA/0xB; a start during RUN is ignored.
REQ-040 SHALL verify: rst asserted at RUN cycle 5 -> after the next edge busy = 0, done = 0, hi = lo = 0, and no done pulse afterwards.
